anillo_ctrl: RTL and testbench
==============================

Name: anillo_ctrl

Overview:
Sequencer for the systolic ring of multiply-accumulate PEs. Each PE runs a 4-phase accumulate/emit cycle driven by its own `cuenta` counter.
- Parks the ring and loads the start vector.
- Aligns all PE phase counters through the shared PE reset.
- Prefetches coefficient columns from a synchronous coefficient ROM.
- Runs a programmed number of ring rounds, flags each fresh result vector, and signals completion.
- Sits between the host/top-level FSM and the PE array plus coefficient memory.

Parameters:
N_PE, 4, PEs in ring = phases per round (power of two, ≥2)
PH_W, 2, log2(N_PE); width of phase and column index
ITER_W, 8, width of round counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low; 0 forces IDLE immediately
start  in  1  run request, sampled in IDLE only
abort  in  1  synchronous cancel, any state
n_iter  in  ITER_W  rounds to run; sampled with start; 0 treated as 1
busy  out  1  high in LOAD and RUN
pe_reset  out  1  active-high synchronous reset to all PEs (loads x_init, clears suma and cuenta)
phase  out  PH_W  current phase within round; mirrors PE cuenta
coef_rd_en  out  1  coefficient ROM read enable
coef_col  out  PH_W  column address to ROM; data returns next cycle
y_valid  out  1  one-cycle pulse: PE y outputs hold a completed round sum
round_cnt  out  ITER_W  rounds completed in current run
done  out  1  one-cycle pulse on completion of final round

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, pe_reset=1, all other outputs 0.

States:
- IDLE:
  - pe_reset=1, phase=0, busy=0.
  - On start=1 and abort=0: latch n_iter (0→1) and go to LOAD.
- LOAD (1 cycle):
  - pe_reset=1, so the PEs capture x_init at the exiting edge.
  - coef_rd_en=1, coef_col=0 (prefetch for phase 0).
  - round_cnt cleared.
  - Next state: RUN with phase=0.
- RUN:
  - pe_reset=0; phase increments each cycle and wraps N_PE-1→0.
  - coef_col=(phase+1) mod N_PE.
  - coef_rd_en=1, except in the final phase of the final round.
  - At each edge leaving phase N_PE-1:
    - round_cnt increments.
    - y_valid=1 for the following cycle.
    - If the new round_cnt equals the latched n_iter, go to DONE; otherwise stay in RUN at phase 0.
- DONE (1 cycle):
  - done=1, y_valid=1 (the same cycle as the final round's y_valid), busy=0, pe_reset=0.
  - PE outputs hold the final result this cycle.
  - Next state: IDLE.

Timing:
- start sampled at edge E0 → LOAD in cycle 1 → RUN phase 0 in cycle 2.
- First y_valid occurs in cycle 2+N_PE.
- done occurs in cycle 2+n_iter·N_PE.

Boundary conditions:
- start while busy or in DONE: ignored, no queuing.
- start and abort high together in IDLE: abort wins, stay in IDLE.
- abort in LOAD/RUN/DONE: go to IDLE next edge.
  - No done pulse.
  - y_valid forced 0 from that edge onward.
  - pe_reset reasserted.
  - round_cnt holds its last value.
- n_iter changes mid-run: no effect (latched copy is used).
- round_cnt does not wrap: n_iter ≤ 2^ITER_W−1.
- Reset deassertion mid-stream: controller starts in IDLE; PEs are held by pe_reset=1 until the next start.

Test Plan:
- Reset then start with n_iter=1, N_PE=4:
  - LOAD in cycle 1, phases 0,1,2,3 in cycles 2–5.
  - y_valid and done high only in cycle 6; busy high in cycles 1–5.
- n_iter=3:
  - y_valid pulses in cycles 6, 10, 14.
  - round_cnt reads 1, 2, 3 after those pulses.
  - done only in cycle 14; coef_col sequence 0,1,2,3,0,… with rd_en low in cycle 13 only.
- n_iter=0: behaves exactly as n_iter=1 (done in cycle 6).
- abort asserted in RUN phase 2 of round 2:
  - IDLE next cycle with pe_reset=1.
  - No done; no further y_valid.
- start pulsed during RUN and in DONE: ignored; the run completes with the original n_iter, and the next start is accepted only from IDLE.
- Asynchronous reset asserted mid-RUN (between edges): outputs go to reset values immediately; subsequent start runs normally.

Source files
------------

// File: rtl/anillo_ctrl.sv
// Ring sequencer for the systolic MAC PE array: parks the ring, aligns PE phase
// counters, prefetches coefficient columns and counts programmed rounds.
module anillo_ctrl #(
  parameter int N_PE   = 4,
  parameter int PH_W   = 2,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] n_iter,
  output logic              busy,
  output logic              pe_reset,
  output logic [PH_W-1:0]   phase,
  output logic              coef_rd_en,
  output logic [PH_W-1:0]   coef_col,
  output logic              y_valid,
  output logic [ITER_W-1:0] round_cnt,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PE - 1);

  state_t            state_r, state_nx;
  logic              busy_r, busy_nx;
  logic              pe_reset_r, pe_reset_nx;
  logic [PH_W-1:0]   phase_r, phase_nx;
  logic              rd_en_r, rd_en_nx;
  logic [PH_W-1:0]   col_r, col_nx;
  logic              y_valid_r, y_valid_nx;
  logic [ITER_W-1:0] round_r, round_nx;
  logic              done_r, done_nx;
  logic [ITER_W-1:0] n_lat_r, n_lat_nx;

  logic [ITER_W-1:0] round_inc_s;
  logic [PH_W-1:0]   phase_inc_s;
  logic              last_round_s;

  assign round_inc_s  = round_r + ITER_W'(1);
  assign phase_inc_s  = phase_r + PH_W'(1);
  assign last_round_s = (round_inc_s == n_lat_r);

  // State and every output are registered together so outputs never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      pe_reset_r <= 1'b1;
      phase_r    <= '0;
      rd_en_r    <= 1'b0;
      col_r      <= '0;
      y_valid_r  <= 1'b0;
      round_r    <= '0;
      done_r     <= 1'b0;
      n_lat_r    <= '0;
    end else begin
      state_r    <= state_nx;
      busy_r     <= busy_nx;
      pe_reset_r <= pe_reset_nx;
      phase_r    <= phase_nx;
      rd_en_r    <= rd_en_nx;
      col_r      <= col_nx;
      y_valid_r  <= y_valid_nx;
      round_r    <= round_nx;
      done_r     <= done_nx;
      n_lat_r    <= n_lat_nx;
    end
  end

  // Next state plus the output values the next state will present.
  always_comb begin
    state_nx    = IDLE;
    busy_nx     = 1'b0;
    pe_reset_nx = 1'b1;
    phase_nx    = '0;
    rd_en_nx    = 1'b0;
    col_nx      = '0;
    y_valid_nx  = 1'b0;
    done_nx     = 1'b0;
    round_nx    = round_r;
    n_lat_nx    = n_lat_r;

    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nx = LOAD;
            n_lat_nx = (n_iter == '0) ? ITER_W'(1) : n_iter;
            round_nx = '0;
            busy_nx  = 1'b1;
            rd_en_nx = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
        LOAD: begin
          state_nx    = RUN;
          busy_nx     = 1'b1;
          pe_reset_nx = 1'b0;
          rd_en_nx    = 1'b1;
          col_nx      = PH_W'(1);
        end
        RUN: begin
          if (phase_r == PH_LAST) begin
            round_nx   = round_inc_s;
            y_valid_nx = 1'b1;
            pe_reset_nx = 1'b0;
            if (last_round_s) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end else begin
              state_nx = RUN;
              busy_nx  = 1'b1;
              rd_en_nx = 1'b1;
              col_nx   = PH_W'(1);
            end
          end else begin
            state_nx    = RUN;
            busy_nx     = 1'b1;
            pe_reset_nx = 1'b0;
            phase_nx    = phase_inc_s;
            col_nx      = phase_inc_s + PH_W'(1);
            // No prefetch is needed once the final phase of the final round starts.
            rd_en_nx    = ~((phase_inc_s == PH_LAST) && last_round_s);
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign pe_reset   = pe_reset_r;
  assign phase      = phase_r;
  assign coef_rd_en = rd_en_r;
  assign coef_col   = col_r;
  assign y_valid    = y_valid_r;
  assign round_cnt  = round_r;
  assign done       = done_r;

endmodule

// File: tb/tb_anillo_ctrl.sv
// Scoreboard bench for anillo_ctrl: stimulus pushes per-cycle expected output
// records, a negedge monitor pops and compares them against the DUT.
module tb_anillo_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] n_iter;
  logic       busy, pe_reset, coef_rd_en, y_valid, done;
  logic [1:0] phase, coef_col;
  logic [7:0] round_cnt;

  typedef struct packed {
    logic       busy;
    logic       pr;
    logic [1:0] ph;
    logic       rd;
    logic [1:0] col;
    logic       yv;
    logic [7:0] rc;
    logic       dn;
  } rec_t;

  rec_t       exp_q[$];
  string      tag_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] last_rc = 8'd0;

  anillo_ctrl #(.N_PE(4), .PH_W(2), .ITER_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .n_iter(n_iter),
    .busy(busy), .pe_reset(pe_reset), .phase(phase), .coef_rd_en(coef_rd_en),
    .coef_col(coef_col), .y_valid(y_valid), .round_cnt(round_cnt), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t idle_rec(input logic [7:0] rc);
    rec_t r;
    r = '0;
    r.pr = 1'b1;
    r.rc = rc;
    return r;
  endfunction

  // Expected outputs k cycles after the start edge for an effective round count n.
  function automatic rec_t run_rec(input int k, input int n);
    rec_t r;
    int ri, p;
    r = '0;
    if (k == 1) begin
      r.busy = 1'b1; r.pr = 1'b1; r.rd = 1'b1;
    end else if (k <= 1 + 4 * n) begin
      ri = (k - 2) / 4;
      p  = (k - 2) % 4;
      r.busy = 1'b1;
      r.ph   = 2'(p);
      r.rd   = !(p == 3 && ri == n - 1);
      r.col  = 2'((p + 1) % 4);
      r.yv   = (p == 0 && ri > 0);
      r.rc   = 8'(ri);
    end else begin
      r.yv = 1'b1;
      r.rc = 8'(n);
      r.dn = 1'b1;
    end
    return r;
  endfunction

  task automatic step(input logic s, input logic a, input logic [7:0] ni,
                      input rec_t e, input string t);
    @(posedge clk);
    #1;
    start = s; abort = a; n_iter = ni;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_run(input int n_prog, input string t);
    int n;
    n = (n_prog == 0) ? 1 : n_prog;
    step(1'b1, 1'b0, 8'(n_prog), idle_rec(last_rc), {t, "_start"});
    for (int k = 1; k <= 2 + 4 * n; k++)
      step(1'b0, 1'b0, 8'(n_prog), run_rec(k, n), t);
    last_rc = 8'(n);
    step(1'b0, 1'b0, 8'(n_prog), idle_rec(last_rc), {t, "_idle"});
  endtask

  // Monitor: compare the DUT outputs against the next queued expectation.
  always @(negedge clk) begin
    rec_t e, g;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {busy, pe_reset, phase, coef_rd_en, coef_col, y_valid, round_cnt, done};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s cyc=%0d got busy=%b pr=%b ph=%0d rd=%b col=%0d yv=%b rc=%0d dn=%b exp busy=%b pr=%b ph=%0d rd=%b col=%0d yv=%b rc=%0d dn=%b",
                 t, cyc, g.busy, g.pr, g.ph, g.rd, g.col, g.yv, g.rc, g.dn,
                 e.busy, e.pr, e.ph, e.rd, e.col, e.yv, e.rc, e.dn);
      end
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; n_iter = 8'd0;
    step(1'b0, 1'b0, 8'd0, idle_rec(8'd0), "reset");
    step(1'b0, 1'b0, 8'd0, idle_rec(8'd0), "reset");
    reset = 1'b1;
    step(1'b0, 1'b0, 8'd0, idle_rec(8'd0), "post_reset");

    do_run(1, "n1");
    do_run(3, "n3");
    do_run(0, "n0");

    // start and abort together in IDLE: abort wins
    step(1'b1, 1'b1, 8'd5, idle_rec(last_rc), "start_abort");
    step(1'b0, 1'b0, 8'd5, idle_rec(last_rc), "start_abort_hold");
    step(1'b0, 1'b0, 8'd5, idle_rec(last_rc), "start_abort_hold");

    // abort in RUN phase 2 of round 2
    step(1'b1, 1'b0, 8'd3, idle_rec(last_rc), "abort_start");
    for (int k = 1; k <= 8; k++)
      step(1'b0, (k == 8), 8'd3, run_rec(k, 3), "abort_run");
    last_rc = 8'd1;
    for (int k = 0; k < 8; k++)
      step(1'b0, 1'b0, 8'd3, idle_rec(last_rc), "after_abort");

    // start pulses during RUN and DONE ignored; n_iter changes mid-run ignored
    step(1'b1, 1'b0, 8'd2, idle_rec(last_rc), "ign_start");
    for (int k = 1; k <= 10; k++)
      step((k == 4 || k == 10), 1'b0, (k >= 3) ? 8'd5 : 8'd2, run_rec(k, 2), "ign_run");
    last_rc = 8'd2;
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 8'd5, idle_rec(last_rc), "ign_idle");
    do_run(1, "after_ign");

    // asynchronous reset between edges mid-RUN
    step(1'b1, 1'b0, 8'd3, idle_rec(last_rc), "arst_start");
    for (int k = 1; k <= 6; k++)
      step(1'b0, 1'b0, 8'd3, run_rec(k, 3), "arst_run");
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.push_back(idle_rec(8'd0));
    tag_q.push_back("arst_now");
    last_rc = 8'd0;
    step(1'b0, 1'b0, 8'd3, idle_rec(8'd0), "arst_hold");
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back(idle_rec(8'd0));
    tag_q.push_back("arst_release");
    step(1'b0, 1'b0, 8'd3, idle_rec(8'd0), "arst_idle");
    do_run(2, "after_arst");

    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
